scalar_recode: RTL

- Sequential stage directly downstream of the scalar nibble decomposer in the Ed25519 scalar-multiplication datapath.
- Accepts 64 unsigned radix-16 nibbles (0..15) and recodes them into signed digits in [-8,8] using the standard carry-propagating recoding.
- Streams the resulting digits, most-significant first, to the point-multiplication controller over a valid/ready handshake.

---
 rtl/ed25519_pkg.sv | 17 +
 rtl/scalar_recode_if.sv | 25 ++
 rtl/recode_step.sv | 21 ++
 rtl/scalar_recode.sv | 128 ++++++++++++
 4 files changed

// File: rtl/ed25519_pkg.sv
// Shared types and constants for the Ed25519 scalar datapath (decomposer and recoder).
package ed25519_pkg;

    localparam int N_DIGITS  = 64;
    localparam int DW        = 8;
    localparam int DIGIT_MAX = 8;
    localparam int RADIX     = 16;
    localparam int IDX_W     = $clog2(N_DIGITS);

    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_DIGITS - 1);

    typedef logic signed [DW-1:0] digit_t;
    typedef digit_t [0:N_DIGITS-1] digit_arr_t;

    typedef enum logic [1:0] {IDLE, RECODE, OUT} recode_state_t;

endpackage

// File: rtl/scalar_recode_if.sv
// Nibble-array input and signed-digit output stream of the scalar recoder.
interface scalar_recode_if;
    import ed25519_pkg::*;

    logic              in_valid;
    logic              in_ready;
    digit_arr_t        in_e;
    logic              dig_valid;
    logic              dig_ready;
    digit_t            dig_data;
    logic [IDX_W-1:0]  dig_idx;
    logic              dig_last;
    logic              range_err;

    modport master (
        output in_valid, in_e, dig_ready,
        input  in_ready, dig_valid, dig_data, dig_idx, dig_last, range_err
    );

    modport slave (
        input  in_valid, in_e, dig_ready,
        output in_ready, dig_valid, dig_data, dig_idx, dig_last, range_err
    );

endinterface

// File: rtl/recode_step.sv
// One step of the radix-16 signed recoding: folds the incoming carry into a nibble and
// re-centres the result into [-8,7], emitting the carry for the next digit.
module recode_step
    import ed25519_pkg::*;
(
    input  digit_t nibble,
    input  logic   carry_in,
    output digit_t digit,
    output logic   carry_out
);

    digit_t t;

    always_comb begin
        t         = nibble + digit_t'(carry_in);
        // t is in [0,16], so (t+8)>>4 reduces to a threshold at 8
        carry_out = (t >= digit_t'(DIGIT_MAX));
        digit     = carry_out ? (t - digit_t'(RADIX)) : t;
    end

endmodule

// File: rtl/scalar_recode.sv
// Recodes 64 radix-16 nibbles into signed digits in [-8,8], one digit per cycle, then
// streams them most-significant first over a valid/ready handshake.
module scalar_recode
    import ed25519_pkg::*;
(
    input  logic            clk,
    input  logic            rst_n,
    scalar_recode_if.slave  bus
);

    localparam digit_t NIB_MASK = digit_t'(8'h0F);

    recode_state_t     state_reg, state_next;
    logic [IDX_W-1:0]  idx_reg;
    logic              carry_reg;
    logic              range_err_reg;
    logic              dig_valid_reg;
    digit_t            dig_data_reg;
    logic [IDX_W-1:0]  dig_idx_reg;
    logic              dig_last_reg;

    digit_t            buf_rd [N_DIGITS];
    digit_t            step_digit;
    logic              step_carry;
    digit_t            top_sum;
    logic              accept;
    logic              fire;

    assign bus.in_ready  = (state_reg == IDLE);
    assign bus.dig_valid = dig_valid_reg;
    assign bus.dig_data  = dig_data_reg;
    assign bus.dig_idx   = dig_idx_reg;
    assign bus.dig_last  = dig_last_reg;
    assign bus.range_err = range_err_reg;

    assign accept  = bus.in_valid && (state_reg == IDLE);
    assign fire    = dig_valid_reg && bus.dig_ready;
    // The top digit keeps its carry instead of re-centring, so it may reach 16
    assign top_sum = buf_rd[N_DIGITS-1] + digit_t'(carry_reg);

    recode_step u_step (
        .nibble    (buf_rd[idx_reg]),
        .carry_in  (carry_reg),
        .digit     (step_digit),
        .carry_out (step_carry)
    );

    genvar gi;
    generate
        for (gi = 0; gi < N_DIGITS; gi++) begin : g_cell
            digit_t cell_reg;
            logic   hit;

            assign hit       = (state_reg == RECODE) && (idx_reg == IDX_W'(gi));
            assign buf_rd[gi] = cell_reg;

            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    cell_reg <= '0;
                end else if (accept) begin
                    cell_reg <= bus.in_e[gi] & NIB_MASK;
                end else if (hit) begin
                    cell_reg <= (gi == N_DIGITS - 1) ? top_sum : step_digit;
                end
            end
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (accept) state_next = RECODE;
            RECODE:  if (idx_reg == LAST_IDX) state_next = OUT;
            OUT:     if (fire && (dig_idx_reg == '0)) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            idx_reg       <= '0;
            carry_reg     <= 1'b0;
            range_err_reg <= 1'b0;
            dig_valid_reg <= 1'b0;
            dig_data_reg  <= '0;
            dig_idx_reg   <= '0;
            dig_last_reg  <= 1'b0;
        end else begin
            state_reg <= state_next;
            case (state_reg)
                IDLE: begin
                    if (accept) begin
                        idx_reg       <= '0;
                        carry_reg     <= 1'b0;
                        range_err_reg <= 1'b0;
                    end
                end
                RECODE: begin
                    if (idx_reg != LAST_IDX) begin
                        carry_reg <= step_carry;
                        idx_reg   <= idx_reg + 1'b1;
                    end else begin
                        range_err_reg <= (top_sum > digit_t'(DIGIT_MAX));
                        dig_valid_reg <= 1'b1;
                        dig_data_reg  <= top_sum;
                        dig_idx_reg   <= LAST_IDX;
                        dig_last_reg  <= 1'b0;
                    end
                end
                OUT: begin
                    if (fire) begin
                        if (dig_idx_reg == '0) begin
                            dig_valid_reg <= 1'b0;
                            dig_last_reg  <= 1'b0;
                        end else begin
                            dig_data_reg <= buf_rd[dig_idx_reg - 1'b1];
                            dig_idx_reg  <= dig_idx_reg - 1'b1;
                            dig_last_reg <= (dig_idx_reg == IDX_W'(1));
                        end
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
